// File: rtl/wbu_pkg.sv
// wbu_pkg: shared widths, CSR addresses and reset constants for the write-back unit
package wbu_pkg;
    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;
    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [DATA_WIDTH-1:0] MSTATUS_RST = 32'h0000_1800;

    function automatic logic csr_valid(input logic [11:0] a);
        return a inside {CSR_MSTATUS, CSR_MTVEC, CSR_MEPC, CSR_MCAUSE,
                         CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH};
    endfunction
endpackage

// File: rtl/wbu_regfile.sv
// regfile: 32x32 GPR file, two read ports with write-through, one write port, x0 hardwired to zero
module regfile
    import wbu_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr1_i,
    input  logic [ADDR_WIDTH-1:0] raddr2_i,
    output logic [DATA_WIDTH-1:0] rdata1_o,
    output logic [DATA_WIDTH-1:0] rdata2_o
);
    logic [DATA_WIDTH-1:0] regs_q [32];
    logic                  wr_en;

    assign wr_en = we_i && (waddr_i != '0);

    // register array: cleared in reset, otherwise written when enabled and target is not x0
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else if (wr_en) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    // read ports: x0 reads zero, a same-cycle write to the read index is forwarded
    always_comb begin
        rdata1_o = (raddr1_i == '0) ? '0 : (wr_en && waddr_i == raddr1_i) ? wdata_i : regs_q[raddr1_i];
        rdata2_o = (raddr2_i == '0) ? '0 : (wr_en && waddr_i == raddr2_i) ? wdata_i : regs_q[raddr2_i];
    end
endmodule

// File: rtl/wbu.sv
// wbu: write-back stage - result select, GPR write, machine CSRs, counters and commit record
module wbu
    import wbu_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  WBReg_RegWr,
    input  logic                  WBReg_MemtoReg,
    input  logic                  WBReg_CSRRegvalid,
    input  logic                  WBReg_CSRRegWr,
    input  logic                  WBReg_CSRset,
    input  logic                  WBReg_ecall,
    input  logic                  WBReg_PCsrc,
    input  logic                  ex_diffen,
    input  logic [ADDR_WIDTH-1:0] WBReg_Regrd,
    input  logic [DATA_WIDTH-1:0] WBReg_ALUout,
    input  logic [DATA_WIDTH-1:0] WBReg_DataOut,
    input  logic [DATA_WIDTH-1:0] WBReg_CSRout,
    input  logic [DATA_WIDTH-1:0] WBReg_ALUa,
    input  logic [DATA_WIDTH-1:0] WBReg_PC,
    input  logic [DATA_WIDTH-1:0] WBReg_Instr,
    input  logic [63:0]           WBReg_ecall_package,
    input  logic [11:0]           WBReg_csr,
    input  logic [ADDR_WIDTH-1:0] rs1,
    input  logic [ADDR_WIDTH-1:0] rs2,
    output logic [DATA_WIDTH-1:0] busA,
    output logic [DATA_WIDTH-1:0] busB,
    output logic [DATA_WIDTH-1:0] busW,
    input  logic [11:0]           csr_raddr,
    output logic [DATA_WIDTH-1:0] csr_rdata,
    output logic [DATA_WIDTH-1:0] mtvec_o,
    output logic [DATA_WIDTH-1:0] mepc_o,
    output logic                  commit_valid,
    output logic [DATA_WIDTH-1:0] commit_pc,
    output logic [DATA_WIDTH-1:0] commit_instr
);
    logic [31:0] mstatus_q, mstatus_d, mtvec_q, mtvec_d, mepc_q, mepc_d, mcause_q, mcause_d;
    logic [63:0] mcycle_q, mcycle_d, minstret_q, minstret_d, cyc_inc, ins_inc;
    logic [31:0] csr_old, csr_wdata;
    logic        csr_wr, pcsrc_unused;
    logic        commit_valid_q;
    logic [31:0] commit_pc_q, commit_instr_q;

    // PCsrc is consumed by execute; it has no write-back effect
    assign pcsrc_unused = WBReg_PCsrc;

    function automatic logic [31:0] csr_sel(input logic [11:0] a, input logic [31:0] ms, mt, me, mc,
                                            input logic [63:0] cy, ir);
        return (a == CSR_MSTATUS)   ? ms :
               (a == CSR_MTVEC)     ? mt :
               (a == CSR_MEPC)      ? me :
               (a == CSR_MCAUSE)    ? mc :
               (a == CSR_MCYCLE)    ? cy[31:0] :
               (a == CSR_MCYCLEH)   ? cy[63:32] :
               (a == CSR_MINSTRET)  ? ir[31:0] :
               (a == CSR_MINSTRETH) ? ir[63:32] : 32'h0;
    endfunction

    assign busW = WBReg_MemtoReg ? WBReg_DataOut : WBReg_CSRRegvalid ? WBReg_CSRout : WBReg_ALUout;

    regfile u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we_i     (WBReg_RegWr),
        .waddr_i  (WBReg_Regrd),
        .wdata_i  (busW),
        .raddr1_i (rs1),
        .raddr2_i (rs2),
        .rdata1_o (busA),
        .rdata2_o (busB)
    );

    // CSR next state: explicit writes, ecall trap capture (wins over writes), counter increments
    always_comb begin
        csr_wr     = WBReg_CSRRegWr && csr_valid(WBReg_csr);
        csr_old    = csr_sel(WBReg_csr, mstatus_q, mtvec_q, mepc_q, mcause_q, mcycle_q, minstret_q);
        csr_wdata  = WBReg_CSRset ? (csr_old | WBReg_ALUa) : WBReg_ALUa;
        cyc_inc    = mcycle_q + 64'd1;
        ins_inc    = minstret_q + {63'd0, ex_diffen};
        mstatus_d  = (csr_wr && WBReg_csr == CSR_MSTATUS) ? csr_wdata : mstatus_q;
        mtvec_d    = (csr_wr && WBReg_csr == CSR_MTVEC) ? csr_wdata : mtvec_q;
        mepc_d     = WBReg_ecall ? WBReg_ecall_package[63:32] :
                     (csr_wr && WBReg_csr == CSR_MEPC) ? csr_wdata : mepc_q;
        mcause_d   = WBReg_ecall ? WBReg_ecall_package[31:0] :
                     (csr_wr && WBReg_csr == CSR_MCAUSE) ? csr_wdata : mcause_q;
        mcycle_d   = {(csr_wr && WBReg_csr == CSR_MCYCLEH) ? csr_wdata :
                      (csr_wr && WBReg_csr == CSR_MCYCLE) ? mcycle_q[63:32] : cyc_inc[63:32],
                      (csr_wr && WBReg_csr == CSR_MCYCLE) ? csr_wdata : cyc_inc[31:0]};
        minstret_d = {(csr_wr && WBReg_csr == CSR_MINSTRETH) ? csr_wdata :
                      (csr_wr && WBReg_csr == CSR_MINSTRET) ? minstret_q[63:32] : ins_inc[63:32],
                      (csr_wr && WBReg_csr == CSR_MINSTRET) ? csr_wdata : ins_inc[31:0]};
        csr_rdata  = (WBReg_ecall && csr_raddr == CSR_MEPC)   ? WBReg_ecall_package[63:32] :
                     (WBReg_ecall && csr_raddr == CSR_MCAUSE) ? WBReg_ecall_package[31:0] :
                     (csr_wr && csr_raddr == WBReg_csr) ? csr_wdata :
                     csr_sel(csr_raddr, mstatus_q, mtvec_q, mepc_q, mcause_q, mcycle_q, minstret_q);
    end

    assign mtvec_o      = mtvec_d;
    assign mepc_o       = mepc_d;
    assign commit_valid = commit_valid_q;
    assign commit_pc    = commit_pc_q;
    assign commit_instr = commit_instr_q;

    // CSR, counter and commit-record registers
    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus_q      <= MSTATUS_RST;
            mtvec_q        <= '0;
            mepc_q         <= '0;
            mcause_q       <= '0;
            mcycle_q       <= '0;
            minstret_q     <= '0;
            commit_valid_q <= 1'b0;
            commit_pc_q    <= '0;
            commit_instr_q <= '0;
        end else begin
            mstatus_q      <= mstatus_d;
            mtvec_q        <= mtvec_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mcycle_q       <= mcycle_d;
            minstret_q     <= minstret_d;
            commit_valid_q <= ex_diffen;
            commit_pc_q    <= WBReg_PC;
            commit_instr_q <= WBReg_Instr;
        end
    end
endmodule

// File: tb/tb_wbu.sv
// tb_wbu: directed vector and sequence bench for the write-back unit
module tb_wbu;
    logic        clk = 0, rst;
    logic        RegWr, MemtoReg, CSRRegvalid, CSRRegWr, CSRset, ecall, PCsrc, diffen;
    logic [4:0]  Regrd, rs1, rs2;
    logic [31:0] ALUout, DataOut, CSRout, ALUa, PC, Instr;
    logic [63:0] pkg;
    logic [11:0] csr, csr_raddr;
    logic [31:0] busA, busB, busW, csr_rdata, mtvec_o, mepc_o, commit_pc, commit_instr;
    logic        commit_valid;
    int          tests = 0, fails = 0;

    typedef struct {
        logic        regwr, mem, csrv;
        logic [4:0]  rd, a1, a2;
        logic [31:0] alu, dout, cout, ew, ea, eb;
    } vec_t;
    vec_t vecs [7];

    always #5 clk = ~clk;

    wbu dut (
        .clk(clk), .rst(rst), .WBReg_RegWr(RegWr), .WBReg_MemtoReg(MemtoReg),
        .WBReg_CSRRegvalid(CSRRegvalid), .WBReg_CSRRegWr(CSRRegWr), .WBReg_CSRset(CSRset),
        .WBReg_ecall(ecall), .WBReg_PCsrc(PCsrc), .ex_diffen(diffen), .WBReg_Regrd(Regrd),
        .WBReg_ALUout(ALUout), .WBReg_DataOut(DataOut), .WBReg_CSRout(CSRout), .WBReg_ALUa(ALUa),
        .WBReg_PC(PC), .WBReg_Instr(Instr), .WBReg_ecall_package(pkg), .WBReg_csr(csr),
        .rs1(rs1), .rs2(rs2), .busA(busA), .busB(busB), .busW(busW), .csr_raddr(csr_raddr),
        .csr_rdata(csr_rdata), .mtvec_o(mtvec_o), .mepc_o(mepc_o), .commit_valid(commit_valid),
        .commit_pc(commit_pc), .commit_instr(commit_instr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bubble();
        {RegWr, MemtoReg, CSRRegvalid, CSRRegWr, CSRset, ecall, PCsrc, diffen} = '0;
        Regrd = 0; rs1 = 0; rs2 = 0; ALUout = 0; DataOut = 0; CSRout = 0; ALUa = 0;
        PC = 0; Instr = 0; pkg = 0; csr = 0; csr_raddr = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [31:0] v, input logic set);
        bubble();
        CSRRegWr = 1; csr = a; ALUa = v; CSRset = set;
    endtask

    task automatic rd_csr(input string name, input logic [11:0] a, input logic [31:0] exp);
        csr_raddr = a;
        #1;
        chk(name, csr_rdata, exp);
    endtask

    initial begin
        vecs[0] = '{1, 1, 0, 5,  5,  0,  32'h1,  32'hDEADBEEF, 0,     32'hDEADBEEF, 32'hDEADBEEF, 0};
        vecs[1] = '{0, 0, 0, 0,  5,  5,  32'h0,  0,            0,     32'h0,        32'hDEADBEEF, 32'hDEADBEEF};
        vecs[2] = '{1, 0, 0, 0,  0,  5,  32'h1234, 0,          0,     32'h1234,     0,            32'hDEADBEEF};
        vecs[3] = '{0, 0, 0, 0,  0,  0,  32'h1234, 0,          0,     32'h1234,     0,            0};
        vecs[4] = '{1, 0, 1, 7,  7,  5,  32'h7,  0,            32'hCAFE, 32'hCAFE,  32'hCAFE,     32'hDEADBEEF};
        vecs[5] = '{1, 1, 1, 31, 7,  31, 32'h0,  32'h11,       32'h22, 32'h11,      32'hCAFE,     32'h11};
        vecs[6] = '{0, 0, 0, 0,  31, 7,  32'h55, 0,            0,     32'h55,       32'h11,       32'hCAFE};
        bubble();
        rst = 1;
        step(); step();
        chk("rst_mtvec", mtvec_o, 0);
        chk("rst_mepc", mepc_o, 0);
        chk("rst_commit_valid", {31'd0, commit_valid}, 0);
        rd_csr("rst_mstatus", 12'h300, 32'h1800);
        rd_csr("rst_mcycle", 12'hB00, 0);
        rst = 0;
        for (int i = 0; i < 7; i++) begin
            bubble();
            RegWr = vecs[i].regwr; MemtoReg = vecs[i].mem; CSRRegvalid = vecs[i].csrv;
            Regrd = vecs[i].rd; rs1 = vecs[i].a1; rs2 = vecs[i].a2;
            ALUout = vecs[i].alu; DataOut = vecs[i].dout; CSRout = vecs[i].cout;
            #1;
            chk($sformatf("v%0d_busW", i), busW, vecs[i].ew);
            chk($sformatf("v%0d_busA", i), busA, vecs[i].ea);
            chk($sformatf("v%0d_busB", i), busB, vecs[i].eb);
            step();
        end
        csr_write(12'h305, 32'hF0, 0);
        #1;
        chk("mtvec_wt", mtvec_o, 32'hF0);
        step();
        csr_write(12'h305, 32'h0F, 1);
        rd_csr("mtvec_set_wt", 12'h305, 32'hFF);
        step();
        bubble();
        #1;
        chk("mtvec_set", mtvec_o, 32'hFF);
        csr_write(12'h123, 32'h5, 0);
        rd_csr("bad_addr", 12'h123, 0);
        step();
        csr_write(12'h341, 32'h5, 0);
        ecall = 1; pkg = {32'h8000_0010, 32'h0000_000B};
        rd_csr("ecall_mepc_wt", 12'h341, 32'h8000_0010);
        chk("ecall_mepc_o_wt", mepc_o, 32'h8000_0010);
        step();
        bubble();
        #1;
        chk("ecall_mepc", mepc_o, 32'h8000_0010);
        rd_csr("ecall_mcause", 12'h342, 32'hB);
        csr_write(12'hB80, 32'hFFFF_FFFF, 0);
        step();
        csr_write(12'hB00, 32'hFFFF_FFFF, 0);
        step();
        bubble();
        rd_csr("mcycle_lo_max", 12'hB00, 32'hFFFF_FFFF);
        rd_csr("mcycle_hi_max", 12'hB80, 32'hFFFF_FFFF);
        step();
        rd_csr("mcycle_lo_wrap", 12'hB00, 0);
        rd_csr("mcycle_hi_wrap", 12'hB80, 0);
        step();
        rd_csr("mcycle_lo_inc", 12'hB00, 1);
        csr_write(12'hB02, 32'h10, 0);
        diffen = 1; PC = 32'h100; Instr = 32'h13;
        rd_csr("minstret_wt", 12'hB02, 32'h10);
        step();
        bubble();
        #1;
        chk("commit_valid1", {31'd0, commit_valid}, 1);
        chk("commit_pc", commit_pc, 32'h100);
        chk("commit_instr", commit_instr, 32'h13);
        rd_csr("minstret_override", 12'hB02, 32'h10);
        diffen = 1; step();
        diffen = 0; step();
        diffen = 1; step();
        bubble();
        rd_csr("minstret_count", 12'hB02, 32'h12);
        rd_csr("minstreth", 12'hB82, 0);
        step();
        chk("commit_valid0", {31'd0, commit_valid}, 0);
        csr_write(12'h300, 32'h0, 0);
        step();
        bubble();
        rd_csr("mstatus_clr", 12'h300, 0);
        rst = 1; RegWr = 1; Regrd = 9; ALUout = 32'h99; diffen = 1;
        step();
        rst = 0;
        bubble();
        rs1 = 5; rs2 = 9;
        #1;
        chk("rst2_x5", busA, 0);
        chk("rst2_x9", busB, 0);
        chk("rst2_commit_valid", {31'd0, commit_valid}, 0);
        rd_csr("rst2_mstatus", 12'h300, 32'h1800);
        rd_csr("rst2_mcycle", 12'hB00, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/wbu.md
WBU -- requirements
Module: wbu

Interface
REQ-001 clk  input  1  clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 WBReg_RegWr, WBReg_MemtoReg, WBReg_CSRRegvalid, WBReg_CSRRegWr, WBReg_CSRset, WBReg_ecall, WBReg_PCsrc, ex_diffen  input  1 each  registered control from execute stage.
REQ-004 WBReg_Regrd  input  5  GPR destination index.
REQ-005 WBReg_ALUout, WBReg_DataOut, WBReg_CSRout, WBReg_ALUa, WBReg_PC, WBReg_Instr  input  32 each  result, load data, old CSR value, CSR operand, PC, instruction.
REQ-006 WBReg_ecall_package  input  64  [63:32] mepc value, [31:0] mcause value.
REQ-007 WBReg_csr  input  12  CSR write address.
REQ-008 rs1, rs2  input  5 each  decode-stage GPR read indices.
REQ-009 busA, busB  output  32 each  GPR read data for decode stage.
REQ-010 busW  output  32  write-back data; also the forwarding source for execute stage.
REQ-011 csr_raddr  input  12;  csr_rdata  output  32  decode-stage CSR read port.
REQ-012 mtvec_o, mepc_o  output  32 each  trap/return targets for execute stage.
REQ-013 commit_valid  output  1;  commit_pc, commit_instr  output  32 each  difftest commit record.

Function
REQ-014 busW SHALL be WBReg_DataOut if MemtoReg, else WBReg_CSRout if CSRRegvalid, else WBReg_ALUout; combinational.
REQ-015 GPR file SHALL be 32x32; write of busW at clk edge when RegWr=1 and Regrd!=0; x0 always reads 0.
REQ-016 busA/busB SHALL read combinationally with write-through: if RegWr=1, Regrd!=0, Regrd==rs1/rs2, return busW.
REQ-017 CSR set: mstatus 0x300, mtvec 0x305, mepc 0x341, mcause 0x342, mcycle 0xB00, mcycleh 0xB80, minstret 0xB02, minstreth 0xB82; other addresses read 0, writes ignored.
REQ-018 CSR write when CSRRegWr=1: new = CSRset ? (old | WBReg_ALUa) : WBReg_ALUa; takes effect at the edge.
REQ-019 ecall=1 SHALL load mepc<=package[63:32], mcause<=package[31:0] at the edge; a same-cycle CSR write to mepc/mcause SHALL be dropped (ecall wins).
REQ-020 csr_rdata SHALL write-through pending CSR write/ecall update of the same address in the same cycle.
REQ-021 mtvec_o/mepc_o SHALL reflect register contents plus same-cycle write-through.
REQ-022 mcycle (64-bit) SHALL increment every non-reset cycle; wraps 0xFFFF_FFFF_FFFF_FFFF -> 0.
REQ-023 minstret (64-bit) SHALL increment when ex_diffen=1; wraps to 0.
REQ-024 Explicit CSR write to a counter half SHALL override that cycle's increment of that half; carry into the other half is suppressed that cycle.
REQ-025 commit_valid/commit_pc/commit_instr SHALL be registered copies of ex_diffen/WBReg_PC/WBReg_Instr, latency 1 cycle.
REQ-026 No stall/flush inputs: every cycle is consumed; bubbles arrive with all write enables low.

Reset
REQ-027 While rst=1: all GPRs 0, mstatus 0x0000_1800, mtvec/mepc/mcause 0, mcycle/minstret 0, commit_valid/commit_pc/commit_instr 0.
REQ-028 Writes presented in a reset cycle SHALL be discarded; first update occurs on the first edge with rst=0.

Structure
REQ-029 CSR address constants, mstatus reset value and DATA_WIDTH/ADDR_WIDTH SHALL live in the shared define header.
REQ-030 GPR file SHALL be a sub-module named regfile (2R1W, write-through); CSR logic stays in wbu.

Verification
REQ-031 MemtoReg=1, DataOut=0xDEAD_BEEF, RegWr=1, Regrd=5 -> next cycle x5=0xDEAD_BEEF; same cycle rs1=5 -> busA=0xDEAD_BEEF.
REQ-032 RegWr=1, Regrd=0, ALUout=0x1234 -> busA with rs1=0 stays 0.
REQ-033 mtvec=0xF0, CSRRegWr=1, CSRset=1, csr=0x305, ALUa=0x0F -> mtvec=0xFF.
REQ-034 ecall=1, package={0x8000_0010,0x0000_000B} plus CSR write mepc=0x5 same cycle -> mepc=0x8000_0010, mcause=0xB.
REQ-035 Write mcycle=0xFFFF_FFFF, mcycleh=0xFFFF_FFFF, then idle -> wraps to 0 after one cycle; minstret counts only ex_diffen pulses.
REQ-036 rst asserted mid-stream with RegWr=1 -> x-regs 0, mstatus 0x1800, commit_valid 0 next cycle.
